// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, controller state codes and beat-index helper for the main-memory responder.
package mem_if_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  function automatic int beatW(input int burst);
    return $clog2(burst);
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word RAM with synchronous write, registered read and a bench preload task.
module mem_array #(
  parameter int DATA_W  = 64,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_W];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // Read register holds its value between reads; contents of mem survive reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  task automatic preload(input int idx, input logic [DATA_W-1:0] v);
    mem[idx] <= v;
  endtask
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency, critical-word-first line responder for L2 bursts.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH_W = 10,
  parameter int BURST   = 4,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_stb,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done
);
  localparam int BW = beatW(BURST);
  localparam int LW = $clog2(LATENCY + 1);
  logic [1:0] state;
  logic weReg;
  logic [DEPTH_W-BW-1:0] lineIdx;
  logic [BW-1:0] startBeat, beatCnt, beatSel, beatOff;
  logic [LW-1:0] latCnt;
  logic [DEPTH_W-1:0] ramAddr;
  logic ramRe, ramWe, accept, lastBeat, unusedAddr;
  assign unusedAddr = ^{mem_addr[ADDR_W-1:DEPTH_W+3], mem_addr[2:0]};
  assign accept = mem_req && (state == IDLE || state == DONE);
  assign lastBeat = beatCnt == BW'(BURST - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      weReg <= 1'b0;
      lineIdx <= '0;
      startBeat <= '0;
      beatCnt <= '0;
      latCnt <= '0;
    end else if (accept) begin
      state <= WAIT;
      weReg <= mem_we;
      lineIdx <= mem_addr[DEPTH_W+2:3+BW];
      startBeat <= mem_addr[2+BW:3];
      latCnt <= LW'(LATENCY - 1);
    end else if (state == WAIT) begin
      latCnt <= latCnt - 1'b1;
      if (latCnt == '0) begin
        state <= XFER;
        beatCnt <= '0;
      end
    end else if (state == XFER) begin
      beatCnt <= beatCnt + 1'b1;
      if (lastBeat) state <= DONE;
    end else if (state == DONE) state <= IDLE;
  // Reads are fetched one beat ahead so data lands with its strobe; writes use the current beat.
  assign ramWe = weReg && state == XFER;
  assign ramRe = !weReg && ((state == WAIT && latCnt == '0) || (state == XFER && !lastBeat));
  assign beatSel = ramWe ? beatCnt : (state == XFER ? beatCnt + 1'b1 : '0);
  assign beatOff = startBeat + beatSel;
  assign ramAddr = {lineIdx, beatOff};
  assign mem_busy = state == WAIT || state == XFER;
  assign mem_stb = state == XFER;
  assign mem_done = state == DONE;
  mem_array #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) uArray (
    .clk(clk),
    .rst_n(rst_n),
    .we(ramWe),
    .re(ramRe),
    .addr(ramAddr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed and random bursts checked against a word-array reference model.
module tb_main_memory_responder;
  localparam int LAT = 4;
  localparam int BURST = 4;
  localparam int WORDS = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_req = 1'b0;
  logic mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [63:0] mem_rdata;
  logic mem_busy, mem_stb, mem_done;
  logic [63:0] model [WORDS];
  int total = 0;
  int bad = 0;

  main_memory_responder #(.ADDR_W(32), .DATA_W(64), .DEPTH_W(10), .BURST(BURST), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_busy(mem_busy),
    .mem_stb(mem_stb),
    .mem_rdata(mem_rdata),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int beatAddr(input int idx, input int k);
    return (idx / BURST) * BURST + ((idx + k) % BURST);
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle so a chained call lands on mem_done.
  task automatic burst(input logic we, input logic [31:0] addr, input int inject, input int abortAt, input bit pre);
    int idx, beats, a;
    idx = int'(addr[12:3]);
    beats = 0;
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = addr;
    @(posedge clk);
    #1 mem_req = 1'b0;
    mem_we = 1'($urandom);
    mem_addr = $urandom;
    for (int cyc = 1; cyc <= LAT + BURST; cyc++) begin
      @(negedge clk);
      mem_req = (cyc == inject);
      check("busy", {63'd0, mem_busy}, 64'd1);
      check("stb", {63'd0, mem_stb}, {63'd0, cyc > LAT});
      if (mem_stb) begin
        a = beatAddr(idx, beats);
        if (we) begin
          mem_wdata = pre ? 64'h1000_0000_0000_0000 + 64'(a) : {$urandom, $urandom};
          model[a] = mem_wdata;
        end else check("rdata", mem_rdata, model[a]);
        beats++;
        if (abortAt != 0 && beats == abortAt) begin
          @(posedge clk);
          #1 rst_n = 1'b0;
          #1 check("abort_stb", {63'd0, mem_stb}, 64'd0);
          check("abort_busy", {63'd0, mem_busy}, 64'd0);
          check("abort_done", {63'd0, mem_done}, 64'd0);
          check("abort_rdata", mem_rdata, 64'd0);
          repeat (2) begin
            @(negedge clk);
            check("abort_nodone", {63'd0, mem_done}, 64'd0);
          end
          rst_n = 1'b1;
          return;
        end
      end
    end
    mem_req = 1'b0;
    @(negedge clk);
    check("done", {63'd0, mem_done}, 64'd1);
    check("done_busy", {63'd0, mem_busy}, 64'd0);
    check("done_stb", {63'd0, mem_stb}, 64'd0);
  endtask

  initial begin
    #1;
    check("rst_busy", {63'd0, mem_busy}, 64'd0);
    check("rst_stb", {63'd0, mem_stb}, 64'd0);
    check("rst_done", {63'd0, mem_done}, 64'd0);
    check("rst_rdata", mem_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l < WORDS / BURST; l++) burst(1'b1, 32'(l * BURST * 8), 0, 0, 1'b1);
    @(negedge clk);
    burst(1'b0, 32'h40, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'h58, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b1, 32'h80, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'h80, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'h60, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'hA0, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, $urandom, 2, 0, 1'b0);
    burst(1'b0, 32'h48, 0, 0, 1'b0);
    @(negedge clk);
    check("idle_done", {63'd0, mem_done}, 64'd0);
    check("idle_busy", {63'd0, mem_busy}, 64'd0);
    burst(1'b1, 32'hC8, 0, 2, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'hC0, 0, 0, 1'b0);
    @(negedge clk);
    burst(1'b0, 32'h2040, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      burst(1'($urandom), $urandom, (i % 3 == 0) ? int'($urandom_range(1, LAT)) : 0, 0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      burst(1'b0, $urandom, 0, 0, 1'b0);
    end
    @(negedge clk);
    check("end_busy", {63'd0, mem_busy}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
Memory-side responder for the L2-to-main-memory interface. It accepts line requests from the L2 cache controller and serves them as bursts of 64-bit beats, each qualified by a strobe. The L2 remains the initiator. Storage is an internal word array with a fixed, programmable access latency, used for simulation and for test-bench closure of the cache hierarchy.

Parameters:
ADDR_W, 32, request address width (byte address)
DATA_W, 64, beat width
DEPTH_W, 10, log2 of number of DATA_W words stored
BURST, 4, beats per cache line (power of 2; line = BURST*8 bytes)
LATENCY, 4, cycles from request acceptance to first beat (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  single-cycle request pulse from L2
mem_we  in  1  1 = line write, 0 = line read; sampled with mem_req
mem_addr  in  ADDR_W  byte address; sampled with mem_req
mem_wdata  in  DATA_W  write beat; L2 drives beat k while mem_stb is high for beat k
mem_busy  out  1  high from acceptance until the last beat completes
mem_stb  out  1  beat strobe; one pulse per beat, BURST pulses per request
mem_rdata  out  DATA_W  read beat; valid only while mem_stb=1 on a read
mem_done  out  1  one-cycle pulse in the cycle after the final beat

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_busy=0, mem_stb=0, mem_done=0, mem_rdata=0; counters cleared. Array contents are not cleared.
- States and transitions:
  - IDLE: mem_req=1 latches we, word index, and start beat; goes to WAIT with lat_cnt=LATENCY-1; mem_busy=1 from the next cycle.
  - WAIT: decrement lat_cnt; at 0 go to XFER with beat_cnt=0.
  - XFER: mem_stb=1 every cycle for BURST consecutive cycles; after beat BURST-1 go to DONE.
  - DONE: mem_done=1 for one cycle, mem_busy=0, then IDLE.
- Latency: first mem_stb occurs exactly LATENCY+1 cycles after the mem_req cycle. A new request is accepted in the cycle mem_done is high.
- Addressing:
  - word index = mem_addr[DEPTH_W+2:3]; bits above are ignored (aliasing).
  - Line base = index with the low log2(BURST) bits cleared.
  - Critical word first: beat k addresses base + ((start + k) mod BURST), where start = index low bits. The sequence wraps within the line and never crosses into the next line.
- Read: the array read is issued one cycle ahead of each strobe, so mem_rdata is valid in the same cycle as mem_stb. mem_rdata holds its last value otherwise.
- Write: mem_wdata is written to the beat address on the rising edge that ends each mem_stb cycle.
- mem_req while mem_busy=1 is ignored, with no queuing. mem_we and mem_addr are don't-care when mem_req=0.
- Reset mid-burst: the burst aborts immediately. Beats already written remain; no mem_done is issued.

Decomposition:
- Package mem_if_pkg:
  - state enum {IDLE, WAIT, XFER, DONE}
  - DATA_W/ADDR_W defaults
  - beat-index width function clog2(BURST)
- Sub-module mem_array: single-port RAM, 2^DEPTH_W x DATA_W, synchronous write and synchronous registered read, with a backdoor preload task for benches.
- The controller FSM and counters live in main_memory_responder.

Test Plan:
1. Preload word i = 64'h1000_0000_0000_0000+i; read request at addr 0x40 (index 8) -> after 5 cycles, 4 stb beats carrying words 8, 9, 10, 11; mem_done one cycle later; mem_busy spanning request+1 to done.
2. Read at addr 0x58 (index 11, start beat 3) -> beats return words 11, 8, 9, 10 (wrap inside line 8..11).
3. Write at addr 0x80 with wdata A0..A3 presented per stb, then read at 0x80 -> read beats A0, A1, A2, A3; no other word changed.
4. Second mem_req pulsed during WAIT -> ignored, exactly 4 stb total; mem_req coincident with mem_done -> accepted, next stb after LATENCY+1 cycles.
5. rst_n low after 2 write beats -> outputs 0 immediately, no mem_done; read of that line shows 2 new words and 2 original.
6. addr with bit DEPTH_W+3 set (0x2040 for DEPTH_W=10) -> aliases to index 8, returns same data as case 1.
